vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
// - Receive side of the VGA link: samples vga_hs/vga_vs/vga_r/g/b on clk_25.
// - Recovers pixel position, checks timing against 640x480@60 geometry, and after
//   lock streams pixel writes (x, y, 24-bit RGB) to a frame-buffer or checker.
// - Used for loopback self-test of the VGA output path and for image capture.
// PARAMETERS
// - H_TOTAL   800  clk_25 cycles per line (hsync fall to hsync fall)
// - V_TOTAL   525  lines per frame (vsync fall to vsync fall)
// - H_START   144  hcount of first active pixel (sync 96 + back porch 48)
// - V_START   35   lcount of first active line (sync 2 + back porch 33)
// - H_ACTIVE  640  active pixels per line
// - V_ACTIVE  480  active lines per frame
// - LOCK_FRAMES 2  consecutive good frames required to assert locked
// PORTS
// - clk_25      in   1   25 MHz pixel clock
// - n_rst       in   1   reset; asynchronous, active-low
// - vga_hs      in   1   horizontal sync, active-low
// - vga_vs      in   1   vertical sync, active-low
// - vga_r/g/b   in   8   colour channels, each 8 bits
// - pix_valid   out  1   pixel write strobe, one per active pixel
// - pix_x       out  10  active x, 0..H_ACTIVE-1
// - pix_y       out  10  active y, 0..V_ACTIVE-1
// - pix_data    out  24  {r,g,b} of this pixel
// - frame_start out  1   1-cycle pulse coinciding with pixel (0,0) while locked
// - locked      out  1   timing verified; pixel stream valid
// - sync_err    out  1   1-cycle pulse on a timing mismatch
// BEHAVIOUR
// - Reset: all outputs 0; state SEARCH; hcount, lcount, good-frame count = 0.
// - All inputs registered once (stage 1). Edge detect uses stage 1 vs its delay.
// - hs fall: hcount <= 0, lcount++. Otherwise hcount++, saturating at 1023.
// - vs fall: lcount <= 0. Takes priority over the hs-fall increment in the same cycle.
// - Line check: at each hs fall, previous hcount+1 must equal H_TOTAL.
// - Frame check: at each vs fall, previous lcount+1 must equal V_TOTAL.
// - The first hs fall after entering SEARCH or MEASURE is not line-checked.
// - FSM:
//   - SEARCH: wait for vs fall -> MEASURE, good count 0.
//   - MEASURE: any failed check -> SEARCH, no sync_err pulse.
//     Each passed frame check increments good count; at LOCK_FRAMES -> LOCKED.
//   - LOCKED: locked=1. Any failed check -> sync_err pulse, locked=0, SEARCH
//     in the same registered update.
//   - The first frame of pixels streams after the vs fall that enters LOCKED.
// - Pixel emit (LOCKED only), for H_START<=hcount<H_START+H_ACTIVE and
//   V_START<=lcount<V_START+V_ACTIVE:
//   - pix_valid=1, pix_x=hcount-H_START, pix_y=lcount-V_START.
//   - pix_data = stage-1 {r,g,b}.
// - Latency: 2 clk_25 cycles, pin to pix_* output, all registered.
// - pix_x/pix_y/pix_data hold their last value when pix_valid=0.
// - Sync outside expected window (e.g. hs low during active pixels) is not checked;
//   only periods are checked.
// - Reset mid-frame: immediate return to reset state; relock needs
//   1 vs fall + LOCK_FRAMES frames.
// CONFIGURATION
// - VGA_CAPTURE_CRC_EN defined:
//   - Adds port frame_crc out 16.
//   - CRC-16-CCITT (poly 0x1021, init 0xFFFF) over pix_data bytes r,g,b for every
//     pix_valid of a frame; 24-bit parallel update per pixel.
//   - frame_crc updates at the vs fall ending a fully streamed locked frame; reset 0.
//   - Running CRC is reinitialised at each frame_start.
// - Not defined: no frame_crc port, no CRC logic; all other behaviour identical.
// TESTING
// - Ideal 640x480 timing, 4 frames -> locked rises at 2nd checked vs fall (frame 3).
//   Frame 3 gives exactly 307200 pix_valid; first pulse carries frame_start,
//   x=0, y=0; last pulse x=639, y=479.
// - Pattern data=x^y per channel -> pix_data matches the pixel at pix_x/pix_y,
//   2-cycle latency.
// - One line 801 cycles long while LOCKED -> sync_err single pulse, locked=0,
//   no pix_valid until relock.
// - Frame of 524 lines during MEASURE -> no sync_err; locked stays 0; relock
//   after 2 further good frames.
// - n_rst asserted mid-line -> all outputs 0 asynchronously; after release,
//   relock on schedule.
// - With VGA_CAPTURE_CRC_EN, all-zero frame -> frame_crc equals golden model
//   value; one pixel flipped -> differs.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA link.
// Samples hsync/vsync/RGB on clk_25, recovers the pixel position, verifies the
// line and frame periods against the configured geometry and, once locked,
// streams one write per active pixel (x, y, 24-bit RGB) two cycles after the pins.
// Optional feature: define VGA_CAPTURE_CRC_EN to add a per-frame CRC-16-CCITT
// output (frame_crc) computed over the streamed pixels of each complete frame.
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_START     = 144,
  parameter int V_START     = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_25,
  input  logic        n_rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err
`ifdef VGA_CAPTURE_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0]    CNT_MAX   = 10'h3FF;
  localparam logic [9:0]    H_START_C = 10'(H_START);
  localparam logic [9:0]    H_END_C   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]    V_START_C = 10'(V_START);
  localparam logic [9:0]    V_END_C   = 10'(V_START + V_ACTIVE);
  localparam logic [10:0]   H_TOT_C   = 11'(H_TOTAL);
  localparam logic [10:0]   V_TOT_C   = 11'(V_TOTAL);
  localparam logic [GW-1:0] LOCK_C    = GW'(LOCK_FRAMES);

  // stage 1 registers and their delayed copies for edge detection
  logic        hs_p1, hs_prev_p1, vs_p1, vs_prev_p1;
  logic [23:0] rgb_p1;

  // position / lock tracking
  logic [9:0]    hcount, lcount, hcount_nxt, lcount_nxt;
  logic [1:0]    state, state_nxt;
  logic [GW-1:0] good, good_nxt;
  logic          skip, skip_nxt;
  logic          err_nxt;
  logic          hs_fall, vs_fall, line_fail, frame_fail;
  logic          emit, origin;

  // Register the sync inputs once and keep a delayed copy for fall detection
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      hs_p1      <= 1'b0;
      hs_prev_p1 <= 1'b0;
      vs_p1      <= 1'b0;
      vs_prev_p1 <= 1'b0;
    end else begin
      hs_p1      <= vga_hs;
      hs_prev_p1 <= hs_p1;
      vs_p1      <= vga_vs;
      vs_prev_p1 <= vs_p1;
    end
  end

  // Register the colour channels once; pure data, so no reset needed
  always_ff @(posedge clk_25) begin
    rgb_p1 <= {vga_r, vga_g, vga_b};
  end

  // ---- stage 1 -> stage 2 boundary: position recovery and lock decisions ----
  assign hs_fall = hs_prev_p1 & ~hs_p1;
  assign vs_fall = vs_prev_p1 & ~vs_p1;

  // The counters hold the position of the previous sample, so the period is count+1.
  assign line_fail  = hs_fall & ~skip & (({1'b0, hcount} + 11'd1) != H_TOT_C);
  assign frame_fail = vs_fall & (({1'b0, lcount} + 11'd1) != V_TOT_C);

  // Next counter values, next FSM state and the sync-error decision
  always_comb begin
    hcount_nxt = hcount;
    lcount_nxt = lcount;
    state_nxt  = state;
    good_nxt   = good;
    skip_nxt   = skip;
    err_nxt    = 1'b0;

    if (hs_fall)
      hcount_nxt = '0;
    else if (hcount != CNT_MAX)
      hcount_nxt = hcount + 10'd1;

    if (vs_fall)
      lcount_nxt = '0;
    else if (hs_fall && (lcount != CNT_MAX))
      lcount_nxt = lcount + 10'd1;

    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nxt = MEASURE;
          good_nxt  = '0;
        end
      end
      MEASURE: begin
        if (line_fail || frame_fail) begin
          state_nxt = SEARCH;
        end else if (vs_fall) begin
          good_nxt = good + GW'(1);
          if ((good + GW'(1)) == LOCK_C)
            state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (line_fail || frame_fail) begin
          state_nxt = SEARCH;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase

    // A line measured from an arbitrary starting point is meaningless, so the
    // first hs fall after (re)entering SEARCH or MEASURE is not checked.
    if ((state_nxt != state) && (state_nxt != LOCKED))
      skip_nxt = 1'b1;
    else if (hs_fall)
      skip_nxt = 1'b0;
  end

  // The next counter values are the position of the sample now in stage 1.
  assign emit   = (state_nxt == LOCKED) &&
                  (hcount_nxt >= H_START_C) && (hcount_nxt < H_END_C) &&
                  (lcount_nxt >= V_START_C) && (lcount_nxt < V_END_C);
  assign origin = (hcount_nxt == H_START_C) && (lcount_nxt == V_START_C);

  // Position counters, FSM state, good-frame count and line-skip flag
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      hcount <= '0;
      lcount <= '0;
      state  <= SEARCH;
      good   <= '0;
      skip   <= 1'b1;
    end else begin
      hcount <= hcount_nxt;
      lcount <= lcount_nxt;
      state  <= state_nxt;
      good   <= good_nxt;
      skip   <= skip_nxt;
    end
  end

  // ---- stage 2 boundary: registered pixel stream and status outputs ----
  // Pixel writes and status pulses; coordinates and data hold between writes
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pix_valid   <= emit;
      frame_start <= emit & origin;
      locked      <= (state_nxt == LOCKED);
      sync_err    <= err_nxt;
      if (emit) begin
        pix_x    <= hcount_nxt - H_START_C;
        pix_y    <= lcount_nxt - V_START_C;
        pix_data <= rgb_p1;
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_run;
  logic        full;

  // CRC-16-CCITT (poly 0x1021), 24 bits per pixel, r first, MSB first
  function automatic logic [15:0] crc16_24(input logic [15:0] crc, input logic [23:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Running CRC restarted at pixel (0,0); published only for frames streamed
  // from their first pixel and closed by a passing frame check
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      crc_run   <= 16'hFFFF;
      full      <= 1'b0;
      frame_crc <= '0;
    end else begin
      if (emit)
        crc_run <= crc16_24(origin ? 16'hFFFF : crc_run, rgb_p1);
      if (vs_fall || (state_nxt != LOCKED))
        full <= 1'b0;
      else if (emit && origin)
        full <= 1'b1;
      if (vs_fall && full && (state == LOCKED) && (state_nxt == LOCKED))
        frame_crc <= crc_run;
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed frame sequence with random colour data, checked
// against a frame-level reference model of lock acquisition and pixel streaming.
// Uses a reduced geometry so the whole sequence runs in about 12k cycles.
module tb_vga_capture;

  localparam int HT  = 40;
  localparam int VT  = 16;
  localparam int HS0 = 10;
  localparam int VS0 = 3;
  localparam int HA  = 24;
  localparam int VA  = 10;
  localparam int HSW = 4;
  localparam int VSW = 2;
  localparam int MID = 8;

  logic        clk_25 = 1'b0;
  logic        n_rst;
  logic        vga_hs, vga_vs;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_data;
  logic        frame_start, locked, sync_err;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
`endif

  vga_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS0), .V_START(VS0),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk_25(clk_25), .n_rst(n_rst), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err)
`ifdef VGA_CAPTURE_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clk_25 = ~clk_25;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: 0 searching, 1 measuring, 2 locked
  int          m_state = 0;
  int          m_good  = 0;
  int          m_err   = 0;
  int          m_prev_lines = 0;
  bit          m_entered = 1'b0;
  logic [44:0] exp_q[$];
  int          n_pix_exp  = 0;
  int          n_pix_seen = 0;
  int          seen_err   = 0;
  logic [44:0] exp_e;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] m_crc = 16'hFFFF;
  logic [15:0] exp_crc = 16'h0000;
  bit          m_full = 1'b0;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] t;
    t = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      t = t[15] ? ((t << 1) ^ 16'h1021) : (t << 1);
    return t;
  endfunction
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // pixel stream and sync-error monitor
  always @(negedge clk_25) begin
    if (n_rst) begin
      if (sync_err) seen_err++;
      if (pix_valid) begin
        n_pix_seen++;
        if (exp_q.size() == 0) begin
          check("pix_extra", 64'(pix_valid), 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("pix", 64'({pix_x, pix_y, pix_data, frame_start}), 64'(exp_e));
        end
      end
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic [7:0] rr,
                       input logic [7:0] gg, input logic [7:0] bb);
    @(posedge clk_25);
    #1;
    vga_hs = hs; vga_vs = vs; vga_r = rr; vga_g = gg; vga_b = bb;
  endtask

  // Model of what the vs fall opening a new frame does.
  task automatic frame_boundary();
`ifdef VGA_CAPTURE_CRC_EN
    bit was_locked;
    was_locked = (m_state == 2);
`endif
    m_entered = 1'b0;
    case (m_state)
      0: begin m_state = 1; m_good = 0; m_entered = 1'b1; end
      1: begin
        if (m_prev_lines == VT) begin
          m_good++;
          if (m_good == 2) m_state = 2;
        end else begin
          m_state = 0;
        end
      end
      default: begin
        if (m_prev_lines != VT) begin m_err++; m_state = 0; end
      end
    endcase
`ifdef VGA_CAPTURE_CRC_EN
    if (was_locked && m_state == 2 && m_full) exp_crc = m_crc;
    m_full = (m_state == 2);
`endif
  endtask

  // One frame of nlines lines; bad_line (if >=0) is one cycle too long;
  // rst_line (if >=0) gets a reset pulse in its front porch.
  task automatic drive_frame(input int nlines, input int bad_line, input int rst_line);
    int len, x, y;
    logic [7:0] rr, gg, bb;
    frame_boundary();
    for (int l = 0; l < nlines; l++) begin
      len = (l == bad_line) ? HT + 1 : HT;
      for (int p = 0; p < len; p++) begin
        x  = p - HS0;
        y  = l - VS0;
        rr = 8'(x ^ y);
        gg = 8'($urandom);
        bb = 8'($urandom);
        drive(!(p < HSW), !(l < VSW), rr, gg, bb);
        if (m_state == 2 && x >= 0 && x < HA && y >= 0 && y < VA) begin
          exp_q.push_back({10'(x), 10'(y), rr, gg, bb, (x == 0 && y == 0)});
          n_pix_exp++;
`ifdef VGA_CAPTURE_CRC_EN
          if (x == 0 && y == 0) m_crc = 16'hFFFF;
          m_crc = crc_byte(crc_byte(crc_byte(m_crc, rr), gg), bb);
`endif
        end
        if (l == rst_line && p == HS0 + HA + 2) begin
          check("locked_pre_rst", 64'(locked), 64'(m_state == 2));
          #2 n_rst = 1'b0;
          #1;
          check("rst_async_out", 64'({pix_valid, pix_x, pix_y, pix_data, frame_start, locked, sync_err}), 64'd0);
          m_state = 0; m_good = 0;
`ifdef VGA_CAPTURE_CRC_EN
          m_full = 1'b0; exp_crc = 16'h0000;
`endif
        end
        if (l == rst_line && p == HS0 + HA + 5) n_rst = 1'b1;
        if (l == MID && p == MID) begin
          check("locked", 64'(locked), 64'(m_state == 2));
          check("sync_err_count", 64'(seen_err), 64'(m_err));
`ifdef VGA_CAPTURE_CRC_EN
          check("frame_crc", 64'(frame_crc), 64'(exp_crc));
`endif
        end
      end
      // the hs fall opening line l+1 checks the length of line l
      if (l == bad_line && l < nlines - 1 && !(m_entered && l == 0)) begin
        if (m_state == 1) begin
          m_state = 0;
        end else if (m_state == 2) begin
          m_err++; m_state = 0;
`ifdef VGA_CAPTURE_CRC_EN
          m_full = 1'b0;
`endif
        end
      end
    end
    m_prev_lines = nlines;
  endtask

  initial begin
    n_rst = 1'b0;
    vga_hs = 1'b1; vga_vs = 1'b1; vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
    repeat (3) @(posedge clk_25);
    #1;
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_frame_start", 64'(frame_start), 64'd0);
    check("rst_pix_bus", 64'({pix_x, pix_y, pix_data}), 64'd0);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);

    // acquisition: locks at the 2nd checked vs fall, frames 3 and 4 stream
    for (int f = 0; f < 4; f++) drive_frame(VT, -1, -1);
    // one long line while locked
    drive_frame(VT, 5, -1);
    for (int f = 0; f < 3; f++) drive_frame(VT, -1, -1);
    // short frame while locked, then good, then short frame while measuring
    drive_frame(VT - 1, -1, -1);
    drive_frame(VT, -1, -1);
    drive_frame(VT - 1, -1, -1);
    for (int f = 0; f < 3; f++) drive_frame(VT, -1, -1);
    // reset in the front porch of a locked frame, then relock
    drive_frame(VT, -1, 5);
    for (int f = 0; f < 3; f++) drive_frame(VT, -1, -1);
    // closing vs fall so the last frame is judged, then idle
    drive_frame(3, -1, -1);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);

    check("pix_drain", 64'(exp_q.size()), 64'd0);
    check("pix_total", 64'(n_pix_seen), 64'(n_pix_exp));
    check("sync_err_final", 64'(seen_err), 64'(m_err));
    check("locked_final", 64'(locked), 64'(m_state == 2));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
